config_source_arbiter: RTL and testbench

Shares the single fabric configuration word port between two word-level config sources: the JTAG config deserializer and the USB config path. Each source delivers 32-bit words as one-cycle strobe pulses without backpressure, plus a level "finished" flag. The arbiter locks onto one source per configuration session, forwards its words with fixed latency, and detects session end or stall timeout. It sits between the source deserializers and the frame/config-register writer.

---
 rtl/cfg_arb_pkg.sv | 20 ++
 rtl/cfg_arb_watchdog.sv | 36 +++
 rtl/config_source_arbiter.sv | 146 ++++++++++++++
 tb/tb_config_source_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cfg_arb_pkg.sv
// Shared definitions for the configuration source arbiter.
package cfg_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_GRANT_JTAG = 3'd1,
    ST_GRANT_USB  = 3'd2,
    ST_DONE       = 3'd3,
    ST_ERR        = 3'd4
  } state_t;

  localparam int GRANT_JTAG_BIT = 0;
  localparam int GRANT_USB_BIT  = 1;

  // True while a source owns the config port.
  function automatic logic is_grant(input state_t s);
    return (s == ST_GRANT_JTAG) || (s == ST_GRANT_USB);
  endfunction

endpackage

// File: rtl/cfg_arb_watchdog.sv
// Stall watchdog: counts enabled cycles since the last clear, saturating.
// expire fires in the cycle whose count update would reach the limit, so
// the owner can change state on that same edge. A limit of 0 never expires.
module cfg_arb_watchdog #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign expire  = en && !clr && (limit != '0) && (cnt_inc >= {1'b0, limit});

  // Next count: clear wins over increment; hold at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && (cnt_q != '1))
      cnt_d = cnt_inc[CNT_W-1:0];
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/config_source_arbiter.sv
// Locks the fabric config word port onto one of two word sources (JTAG or
// USB) per session, forwards its words with one cycle of latency, and ends
// the session on the source's finished flag or on a stall timeout.
module config_source_arbiter
  import cfg_arb_pkg::*;
#(
  parameter int WORD_W         = 32,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jtag_strobe,
  input  logic [WORD_W-1:0] jtag_data,
  input  logic              jtag_finished,
  input  logic              usb_strobe,
  input  logic [WORD_W-1:0] usb_data,
  input  logic              usb_finished,
  input  logic              rearm,
  output logic              cfg_strobe,
  output logic [WORD_W-1:0] cfg_data,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              cfg_done,
  output logic              timeout_err,
  output logic              conflict,
  output logic [CNT_W-1:0]  word_count
);

  state_t              state_q, state_d;
  logic                cfg_strobe_q, cfg_strobe_d;
  logic [WORD_W-1:0]   cfg_data_q, cfg_data_d;
  logic                conflict_q, conflict_d;
  logic [CNT_W-1:0]    word_count_q, word_count_d, word_count_inc;
  logic                wd_clr, wd_en, wd_expire;
  logic                jtag_elig, usb_elig;

  // A source that has already declared itself finished cannot open a session.
  assign jtag_elig      = jtag_strobe && !jtag_finished;
  assign usb_elig       = usb_strobe  && !usb_finished;
  assign word_count_inc = (word_count_q == '1) ? word_count_q : word_count_q + CNT_W'(1);

  cfg_arb_watchdog #(.CNT_W(CNT_W)) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (wd_clr),
    .en     (wd_en),
    .limit  (CNT_W'(TIMEOUT_CYCLES)),
    .expire (wd_expire)
  );

  // Session FSM: grant selection, word forwarding, conflict and end detection.
  always_comb begin
    state_d      = state_q;
    cfg_strobe_d = 1'b0;
    cfg_data_d   = cfg_data_q;
    conflict_d   = conflict_q;
    word_count_d = word_count_q;
    wd_clr       = 1'b0;
    wd_en        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (jtag_elig) begin
          state_d      = ST_GRANT_JTAG;
          cfg_strobe_d = 1'b1;
          cfg_data_d   = jtag_data;
          word_count_d = CNT_W'(1);
          wd_clr       = 1'b1;
          // Simultaneous USB word is lost; flag it.
          if (usb_elig) conflict_d = 1'b1;
        end else if (usb_elig) begin
          state_d      = ST_GRANT_USB;
          cfg_strobe_d = 1'b1;
          cfg_data_d   = usb_data;
          word_count_d = CNT_W'(1);
          wd_clr       = 1'b1;
        end
      end
      ST_GRANT_JTAG: begin
        wd_en = 1'b1;
        if (jtag_strobe) begin
          cfg_strobe_d = 1'b1;
          cfg_data_d   = jtag_data;
          word_count_d = word_count_inc;
          wd_clr       = 1'b1;
        end
        if (usb_strobe) conflict_d = 1'b1;
        // finished outranks a same-cycle timeout.
        if (jtag_finished)  state_d = ST_DONE;
        else if (wd_expire) state_d = ST_ERR;
      end
      ST_GRANT_USB: begin
        wd_en = 1'b1;
        if (usb_strobe) begin
          cfg_strobe_d = 1'b1;
          cfg_data_d   = usb_data;
          word_count_d = word_count_inc;
          wd_clr       = 1'b1;
        end
        if (jtag_strobe) conflict_d = 1'b1;
        if (usb_finished)   state_d = ST_DONE;
        else if (wd_expire) state_d = ST_ERR;
      end
      ST_DONE, ST_ERR: begin
        if (rearm) begin
          state_d    = ST_IDLE;
          conflict_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset also kills any in-flight strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cfg_strobe_q <= 1'b0;
      cfg_data_q   <= '0;
      conflict_q   <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cfg_strobe_q <= cfg_strobe_d;
      cfg_data_q   <= cfg_data_d;
      conflict_q   <= conflict_d;
      word_count_q <= word_count_d;
    end
  end

  // Status decode from the registered state.
  always_comb begin
    grant                 = '0;
    grant[GRANT_JTAG_BIT] = (state_q == ST_GRANT_JTAG);
    grant[GRANT_USB_BIT]  = (state_q == ST_GRANT_USB);
  end

  assign busy        = is_grant(state_q);
  assign cfg_done    = (state_q == ST_DONE);
  assign timeout_err = (state_q == ST_ERR);
  assign cfg_strobe  = cfg_strobe_q;
  assign cfg_data    = cfg_data_q;
  assign conflict    = conflict_q;
  assign word_count  = word_count_q;

endmodule

// File: tb/tb_config_source_arbiter.sv
// Directed bench for config_source_arbiter with a word scoreboard.
module tb_config_source_arbiter;

  localparam int WORD_W = 32;
  localparam int TOUT   = 8;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              jtag_strobe = 1'b0, usb_strobe = 1'b0;
  logic [WORD_W-1:0] jtag_data = '0, usb_data = '0;
  logic              jtag_finished = 1'b0, usb_finished = 1'b0;
  logic              rearm = 1'b0;
  logic              cfg_strobe;
  logic [WORD_W-1:0] cfg_data;
  logic [1:0]        grant;
  logic              busy, cfg_done, timeout_err, conflict;
  logic [CNT_W-1:0]  word_count;

  int passed = 0;
  int total  = 0;
  logic [WORD_W-1:0] exp_q[$];

  config_source_arbiter #(.WORD_W(WORD_W), .TIMEOUT_CYCLES(TOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .jtag_strobe(jtag_strobe), .jtag_data(jtag_data), .jtag_finished(jtag_finished),
    .usb_strobe(usb_strobe), .usb_data(usb_data), .usb_finished(usb_finished),
    .rearm(rearm), .cfg_strobe(cfg_strobe), .cfg_data(cfg_data), .grant(grant),
    .busy(busy), .cfg_done(cfg_done), .timeout_err(timeout_err),
    .conflict(conflict), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one edge, then check the forwarded word stream against the queue.
  task automatic tick();
    logic              vld;
    logic [WORD_W-1:0] w;
    @(posedge clk); #1;
    vld = (exp_q.size() != 0);
    chk("cfg_strobe", {63'd0, cfg_strobe}, {63'd0, vld});
    if (vld) begin
      w = exp_q.pop_front();
      if (cfg_strobe) chk("cfg_data", {32'd0, cfg_data}, {32'd0, w});
    end
  endtask

  task automatic cyc(input logic js, input logic [WORD_W-1:0] jd,
                     input logic us, input logic [WORD_W-1:0] ud, input logic rm);
    jtag_strobe = js; jtag_data = jd;
    usb_strobe  = us; usb_data  = ud;
    rearm       = rm;
    tick();
    jtag_strobe = 1'b0; usb_strobe = 1'b0; rearm = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_conflict", conflict, 0);
    chk("rst_wc", word_count, 0);
    chk("rst_data", cfg_data, 0);
    reset = 1'b1;
    tick();

    // JTAG session of three words
    exp_q.push_back(32'hA1); cyc(1, 32'hA1, 0, 0, 0);
    chk("t1_grant", grant, 2'b01);
    chk("t1_busy", busy, 1);
    exp_q.push_back(32'hA2); cyc(1, 32'hA2, 0, 0, 0);
    exp_q.push_back(32'hA3); cyc(1, 32'hA3, 0, 0, 0);
    jtag_finished = 1'b1; cyc(0, 0, 0, 0, 0);
    chk("t1_done", cfg_done, 1);
    chk("t1_busy_end", busy, 0);
    chk("t1_grant_end", grant, 0);
    chk("t1_wc", word_count, 3);
    chk("t1_data_hold", cfg_data, 32'hA3);
    jtag_finished = 1'b0; cyc(0, 0, 0, 0, 1);
    chk("t1_rearm", cfg_done, 0);

    // Simultaneous eligible strobes from IDLE: JTAG wins
    exp_q.push_back(32'h11); cyc(1, 32'h11, 1, 32'h22, 0);
    chk("t2_grant", grant, 2'b01);
    chk("t2_conflict", conflict, 1);
    jtag_finished = 1'b1; cyc(0, 0, 0, 0, 0);
    jtag_finished = 1'b0; cyc(0, 0, 0, 0, 1);
    chk("t2_conflict_clr", conflict, 0);

    // USB session with an intruding JTAG word and a stray rearm
    exp_q.push_back(32'h31); cyc(0, 0, 1, 32'h31, 0);
    chk("t3_grant", grant, 2'b10);
    exp_q.push_back(32'h32); cyc(0, 0, 1, 32'h32, 1);
    chk("t3_rearm_ignored", busy, 1);
    cyc(1, 32'hDEAD, 0, 0, 0);
    chk("t3_conflict", conflict, 1);
    chk("t3_no_dead", cfg_data, 32'h32);
    exp_q.push_back(32'h33); cyc(0, 0, 1, 32'h33, 0);
    chk("t3_wc", word_count, 3);
    usb_finished = 1'b1; cyc(0, 0, 0, 0, 0);
    chk("t3_done", cfg_done, 1);
    usb_finished = 1'b0; cyc(0, 0, 0, 0, 1);

    // Timeout: one USB word, then silence with a non-granted strobe
    exp_q.push_back(32'h41); cyc(0, 0, 1, 32'h41, 0);
    cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    cyc(1, 32'h77, 0, 0, 0);
    cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    chk("t4_not_yet", timeout_err, 0);
    chk("t4_busy_7", busy, 1);
    cyc(0, 0, 0, 0, 0);
    chk("t4_err", timeout_err, 1);
    chk("t4_grant", grant, 0);
    chk("t4_conflict", conflict, 1);
    cyc(0, 0, 1, 32'h42, 0);
    chk("t4_err_hold", timeout_err, 1);
    chk("t4_wc_hold", word_count, 1);
    cyc(0, 0, 0, 0, 1);
    chk("t4_rearm_err", timeout_err, 0);
    chk("t4_rearm_conflict", conflict, 0);
    chk("t4_wc_after_rearm", word_count, 1);

    // Last word and finished in the same cycle
    exp_q.push_back(32'h54); cyc(0, 0, 1, 32'h54, 0);
    usb_finished = 1'b1;
    exp_q.push_back(32'h55); cyc(0, 0, 1, 32'h55, 0);
    chk("t5_done", cfg_done, 1);
    chk("t5_wc", word_count, 2);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 32'h56, 0);
    chk("t5_no_grant", grant, 0);
    chk("t5_not_busy", busy, 0);
    chk("t5_wc_hold", word_count, 2);
    usb_finished = 1'b0;

    // word_count saturation with back-to-back words
    for (int i = 0; i < 17; i++) begin
      exp_q.push_back(32'h100 + i);
      cyc(1, 32'h100 + i, 0, 0, 0);
    end
    chk("sat_wc", word_count, 15);
    chk("sat_busy", busy, 1);
    jtag_finished = 1'b1; cyc(0, 0, 0, 0, 0);
    jtag_finished = 1'b0; cyc(0, 0, 0, 0, 1);

    // Asynchronous reset right after a granted strobe
    exp_q.push_back(32'h61); cyc(1, 32'h61, 1, 32'h99, 0);
    chk("t6_conflict_pre", conflict, 1);
    reset = 1'b0; #1;
    chk("t6_strobe_killed", cfg_strobe, 0);
    chk("t6_grant", grant, 0);
    chk("t6_busy", busy, 0);
    chk("t6_conflict", conflict, 0);
    chk("t6_wc", word_count, 0);
    tick();
    reset = 1'b1;
    exp_q.push_back(32'h62); cyc(1, 32'h62, 0, 0, 0);
    chk("t6_new_wc", word_count, 1);
    chk("t6_new_grant", grant, 2'b01);
    tick();
    chk("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
